sump_host: RTL and testbench
============================

SUMP_HOST -- requirements
Module: sump_host

Interface
REQ-001 Parameter FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter RATE, default 115200, UART baud rate; bit period BIT = FREQ/RATE clocks, integer-truncated.
REQ-003 clock  in  1  single system clock; all logic rising-edge.
REQ-004 extReset  in  1  reset, synchronous, active-low.
REQ-005 cmd_valid  in  1  command offered; cmd_op[7:0], cmd_data[31:0] held stable while cmd_valid && !cmd_ready.
REQ-006 cmd_op  in  8  SUMP opcode; bit7=1 marks a long command.
REQ-007 cmd_data  in  32  long-command argument; ignored for short commands.
REQ-008 cmd_ready  out  1  high only in TX IDLE; command accepted on cmd_valid && cmd_ready.
REQ-009 tx  out  1  UART 8N1 line to the analyzer, idle high.
REQ-010 rx  in  1  UART 8N1 line from the analyzer, asynchronous.
REQ-011 rsp_flush  in  1  single-cycle request to emit a partially assembled response word.
REQ-012 rsp_valid  out  1  one-cycle pulse, rsp_data valid.
REQ-013 rsp_data  out  32  assembled response.
REQ-014 frame_err  out  1  one-cycle pulse on an rx byte whose stop bit sampled low.

Function
REQ-015 Short command (cmd_op[7]=0) SHALL transmit 1 byte: cmd_op.
REQ-016 Long command SHALL transmit 5 bytes: cmd_op, then cmd_data[7:0], [15:8], [23:16], [31:24].
REQ-017 Each byte SHALL be framed start(0), 8 data bits LSB first, stop(1), each bit exactly BIT clocks.
REQ-018 TX FSM states IDLE, START, DATA, STOP; IDLE->START on accept; STOP->START if bytes remain, else ->IDLE.
REQ-019 tx SHALL go low the cycle after acceptance; cmd_ready low from that cycle until STOP of the last byte completes.
REQ-020 Back-to-back commands SHALL leave exactly one idle cycle (IDLE state) between stop bit of one and start bit of the next.
REQ-021 RX SHALL synchronize rx through two flops before use.
REQ-022 RX SHALL detect a falling edge, confirm low at BIT/2, then sample data bits and stop bit at successive BIT intervals from that point.
REQ-023 Start bit sampled high at BIT/2 SHALL be treated as a glitch: return to idle, no byte, no frame_err.
REQ-024 Bytes with bad stop bit SHALL be discarded and pulse frame_err; the assembler is unaffected.
REQ-025 Assembler SHALL pack good bytes little-endian (first byte -> rsp_data[7:0]); 4th byte pulses rsp_valid the cycle after its stop-bit sample and clears the count.
REQ-026 rsp_flush with 1-3 bytes pending SHALL pulse rsp_valid next cycle, unfilled bytes zero; with 0 pending SHALL do nothing.
REQ-027 rsp_flush coinciding with a completing byte: the byte is included first, then the word emitted (one pulse).
REQ-028 TX and RX SHALL operate independently and concurrently.

Reset
REQ-029 Under extReset low: tx=1, cmd_ready=0, rsp_valid=0, rsp_data=0, frame_err=0, both FSMs idle, byte count 0, rx synchronizer set to 1.
REQ-030 Reset mid-frame SHALL abort the byte immediately; partial words and the in-flight command are dropped; cmd_ready rises the first cycle after reset release.

Configuration
REQ-031 Macro SUMP_HOST_WORD_EN: defined -> REQ-025..027 word assembly.
REQ-032 Undefined -> every good byte pulses rsp_valid with rsp_data={24'h0,byte}; rsp_flush ignored.

Structure
REQ-033 Package sump_pkg SHALL hold opcode constants (RESET 8'h00, RUN 8'h01, ID 8'h02, METADATA 8'h04, XON 8'h11, XOFF 8'h13) and the TX/RX state typedefs.
REQ-034 Sub-module sump_host_uart_rx SHALL contain sync, RX FSM and bit counter, outputting byte, byte_valid, frame_err; TX and assembler stay in sump_host.

Verification (FREQ=1000000, RATE=125000, BIT=8)
REQ-035 Short cmd 8'h02 -> tx frame 0,0,1,0,0,0,0,0,0,1 at 8 clocks/bit, 80 clocks total; cmd_ready returns after.
REQ-036 Long cmd 8'hC0/32'h11223344 -> bytes C0,44,33,22,11 on tx; 5 frames with 1 idle cycle before next accept.
REQ-037 Loop tx to rx, send 4 short cmds 8'h78,8'h56,8'h34,8'h12 -> single rsp_valid, rsp_data=32'h12345678.
REQ-038 Drive rx byte 8'hAA then 8'h55 with stop bit low -> rsp_flush gives rsp_data=32'h000000AA, one frame_err pulse.
REQ-039 3-clock low glitch on rx -> no byte, no frame_err; following byte 8'h5A received intact.
REQ-040 extReset low for 1 cycle during 3rd bit of long cmd -> tx=1 next cycle, no further bytes; new cmd accepted after release.

Source files
------------

// File: rtl/sump_pkg.sv
// SUMP host shared definitions: opcodes, FSM state types, command helpers.
// Latency: none (declarations only).
// Backpressure: n/a.
package sump_pkg;

  localparam logic [7:0] OP_RESET    = 8'h00;
  localparam logic [7:0] OP_RUN      = 8'h01;
  localparam logic [7:0] OP_ID       = 8'h02;
  localparam logic [7:0] OP_METADATA = 8'h04;
  localparam logic [7:0] OP_XON      = 8'h11;
  localparam logic [7:0] OP_XOFF     = 8'h13;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bit 7 of the opcode marks a long command carrying a 32-bit argument.
  function automatic logic is_long(input logic [7:0] op);
    return op[7];
  endfunction

endpackage

// File: rtl/sump_host_if.sv
// SUMP host command / response bundle between a controller and the host block.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; responses are unthrottled pulses.
interface sump_host_if;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        rsp_flush;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        frame_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_flush,
    input  cmd_ready, rsp_valid, rsp_data, frame_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_flush,
    output cmd_ready, rsp_valid, rsp_data, frame_err
  );
endinterface

// File: rtl/sump_host_uart_rx.sv
// UART 8N1 receiver: two-flop sync, mid-bit sampling, glitch and stop-bit check.
// Latency: byte_valid/frame_err asserted combinationally in the stop-bit sample cycle.
// Backpressure: none; each byte is presented for exactly one cycle.
module sump_host_uart_rx
  import sump_pkg::*;
#(
  parameter int BIT = 8
) (
  input  logic       clock,
  input  logic       extReset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT + 1);

  logic            sync1, sync2, prev;
  rx_state_t       state, state_nx;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            hit_half, hit_bit;

  // cnt reads k on the k-th cycle after the falling edge was seen
  assign hit_half = (cnt == CW'(HALF));
  assign hit_bit  = (cnt == CW'(BIT));
  assign rx_byte  = shift;

  // Synchroniser and edge history idle high so reset never looks like a start bit
  always_ff @(posedge clock) begin
    if (!extReset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!extReset) state <= RX_IDLE;
    else           state <= state_nx;
  end

  // Next state and the stop-bit verdict
  always_comb begin
    state_nx   = state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      RX_IDLE:  if (prev && !sync2) state_nx = RX_START;
      RX_START: if (hit_half) state_nx = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (hit_bit && bit_idx == 3'd7) state_nx = RX_STOP;
      RX_STOP: begin
        if (hit_bit) begin
          state_nx   = RX_IDLE;
          byte_valid = sync2;
          frame_err  = !sync2;
        end
      end
      default:  state_nx = RX_IDLE;
    endcase
  end

  // Bit timer and LSB-first shift register
  always_ff @(posedge clock) begin
    if (!extReset) begin
      cnt     <= CW'(1);
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      case (state)
        RX_IDLE: begin
          cnt     <= CW'(1);
          bit_idx <= 3'd0;
        end
        RX_START: cnt <= hit_half ? CW'(1) : cnt + 1'b1;
        RX_DATA: begin
          if (hit_bit) begin
            cnt     <= CW'(1);
            shift   <= {sync2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP:  cnt <= hit_bit ? CW'(1) : cnt + 1'b1;
        default:  cnt <= CW'(1);
      endcase
    end
  end

endmodule

// File: rtl/sump_host.sv
// SUMP host: serialises 1/5-byte commands on tx, returns rx bytes (or words with SUMP_HOST_WORD_EN).
// Latency: tx start bit the cycle after accept; rsp_valid one cycle after the stop-bit sample or flush.
// Backpressure: cmd_ready only in TX idle; responses are pulses and cannot be stalled.
module sump_host
  import sump_pkg::*;
#(
  parameter int FREQ = 100000000,
  parameter int RATE = 115200
) (
  input  logic        clock,
  input  logic        extReset,
  sump_host_if.slave  bus,
  output logic        tx,
  input  logic        rx
);

  localparam int BIT = FREQ / RATE;
  localparam int CW  = $clog2(BIT + 1);

  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic [31:0]   tx_pend;
  logic [2:0]    tx_left;
  logic          run_q;
  logic          bit_done, accept;

  assign bit_done      = (tx_cnt == CW'(BIT - 1));
  assign bus.cmd_ready = run_q && (tx_state == TX_IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // TX state register
  always_ff @(posedge clock) begin
    if (!extReset) tx_state <= TX_IDLE;
    else           tx_state <= tx_next;
  end

  // TX next state; STOP always passes through IDLE before the next command
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (accept) tx_next = TX_START;
      TX_START: if (bit_done) tx_next = TX_DATA;
      TX_DATA:  if (bit_done && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (bit_done) tx_next = (tx_left != 3'd0) ? TX_START : TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Line level follows the state directly so reset forces it high at once
  always_comb begin
    tx = 1'b1;
    case (tx_state)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tx_shift[0];
      default:  tx = 1'b1;
    endcase
  end

  // TX datapath: bit timer, byte shifter and the queue of argument bytes
  always_ff @(posedge clock) begin
    if (!extReset) begin
      run_q    <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx_pend  <= 32'h0;
      tx_left  <= 3'd0;
    end else begin
      run_q <= 1'b1;
      if (tx_state == TX_IDLE) begin
        tx_cnt <= '0;
        tx_bit <= 3'd0;
        if (accept) begin
          tx_shift <= bus.cmd_op;
          tx_pend  <= bus.cmd_data;
          tx_left  <= is_long(bus.cmd_op) ? 3'd4 : 3'd0;
        end
      end else if (bit_done) begin
        tx_cnt <= '0;
        if (tx_state == TX_DATA) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
        if (tx_state == TX_STOP && tx_left != 3'd0) begin
          tx_shift <= tx_pend[7:0];
          tx_pend  <= {8'h00, tx_pend[31:8]};
          tx_left  <= tx_left - 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  logic [7:0] rx_byte;
  logic       rx_vld, rx_ferr;

  sump_host_uart_rx #(.BIT(BIT)) u_rx (
    .clock      (clock),
    .extReset   (extReset),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (rx_vld),
    .frame_err  (rx_ferr)
  );

  // Frame error is reported as a registered one-cycle pulse
  always_ff @(posedge clock) begin
    if (!extReset) bus.frame_err <= 1'b0;
    else           bus.frame_err <= rx_ferr;
  end

`ifdef SUMP_HOST_WORD_EN
  logic [1:0]  asm_cnt;
  logic [31:0] asm_word, word_n;
  logic [2:0]  fill;
  logic        emit;

  // Merge the arriving byte first so a coincident flush includes it
  always_comb begin
    word_n = asm_word;
    if (rx_vld) word_n[{asm_cnt, 3'b000} +: 8] = rx_byte;
    fill = {1'b0, asm_cnt} + {2'b00, rx_vld};
    emit = (fill == 3'd4) || (bus.rsp_flush && fill != 3'd0);
  end

  // Little-endian word assembler; the emitted word starts the next one from zero
  always_ff @(posedge clock) begin
    if (!extReset) begin
      asm_cnt       <= 2'd0;
      asm_word      <= 32'h0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 32'h0;
    end else begin
      bus.rsp_valid <= emit;
      if (emit) begin
        bus.rsp_data <= word_n;
        asm_word     <= 32'h0;
        asm_cnt      <= 2'd0;
      end else begin
        asm_word <= word_n;
        asm_cnt  <= fill[1:0];
      end
    end
  end
`else
  logic unused_flush;
  assign unused_flush = bus.rsp_flush;

  // Byte mode: every good byte becomes its own zero-extended response
  always_ff @(posedge clock) begin
    if (!extReset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 32'h0;
    end else begin
      bus.rsp_valid <= rx_vld;
      if (rx_vld) bus.rsp_data <= {24'h0, rx_byte};
    end
  end
`endif

endmodule

// File: tb/tb_sump_host.sv
// Self-checking bench for sump_host at BIT = 8 clocks, byte or word response mode.
module tb_sump_host;
  import sump_pkg::*;

  localparam int FREQ = 1000000;
  localparam int RATE = 125000;
  localparam int BIT  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, rx;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  bit   mon_en = 1'b1;

  always #5 clk = ~clk;

  sump_host_if bus ();

  sump_host #(.FREQ(FREQ), .RATE(RATE)) dut (
    .clock    (clk),
    .extReset (rst_n),
    .bus      (bus),
    .tx       (tx),
    .rx       (rx)
  );

  assign rx = loop_en ? tx : rx_drv;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rsp[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (bus.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

  // Response scoreboard
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (exp_rsp.size() == 0) check("rsp_unexpected", bus.rsp_data, 32'hdeadbeef);
      else                     check("rsp_data", bus.rsp_data, exp_rsp.pop_front());
    end
  end

  // tx line decoder: every bit must hold for exactly BIT samples
  initial begin
    logic       prev;
    logic [9:0] bits;
    logic       bad;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && tx === 1'b0) begin
        bad = 1'b0;
        bits = '0;
        for (int i = 0; i < 10; i++) begin
          for (int c = 0; c < BIT; c++) begin
            if (c == 0) bits[i] = tx;
            else if (tx !== bits[i]) bad = 1'b1;
            if (!(i == 9 && c == BIT - 1)) @(negedge clk);
          end
        end
        check("tx_frame_shape", {29'h0, bad, bits[0], bits[9]}, 32'h1);
        if (exp_tx.size() == 0) check("tx_unexpected", {24'h0, bits[8:1]}, 32'hdeadbeef);
        else                    check("tx_byte", {24'h0, bits[8:1]}, {24'h0, exp_tx.pop_front()});
        prev = 1'b1;
      end else begin
        prev = tx;
      end
    end
  end

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] data, output int acc);
    int n;
    n = 0;
    exp_tx.push_back(op);
    if (op[7]) for (int i = 0; i < 4; i++) exp_tx.push_back(data[8*i +: 8]);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    while (bus.cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", {31'h0, bus.cmd_ready}, 32'h1);
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    check("ready_low_after_accept", {31'h0, bus.cmd_ready}, 32'h0);
    check("tx_low_after_accept", {31'h0, tx}, 32'h0);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_drv = stop;
    repeat (BIT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.rsp_flush = 1'b1;
    @(negedge clk);
    bus.rsp_flush = 1'b0;
  endtask

  initial begin
    int a0, a1, a2, lows;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 8'h00;
    bus.cmd_data  = 32'h0;
    bus.rsp_flush = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {31'h0, bus.cmd_ready}, 32'h1);

    // Short command: single 80-clock frame
    send_cmd(OP_ID, 32'h0, a0);
    repeat (85) @(negedge clk);
    check("ready_returns", {31'h0, bus.cmd_ready}, 32'h1);

    // Long command followed back-to-back by a short one: one idle cycle between
    send_cmd(8'hC0, 32'h11223344, a1);
    send_cmd(OP_RUN, 32'h0, a2);
    check("gap_long_cmd", a2 - a1, 32'd401);
    repeat (90) @(negedge clk);

    // Loopback of four short commands
    loop_en = 1'b1;
`ifdef SUMP_HOST_WORD_EN
    exp_rsp.push_back(32'h12345678);
`else
    exp_rsp.push_back(32'h78);
    exp_rsp.push_back(32'h56);
    exp_rsp.push_back(32'h34);
    exp_rsp.push_back(32'h12);
`endif
    send_cmd(8'h78, 32'h0, a1);
    send_cmd(8'h56, 32'h0, a2);
    check("gap_short_cmd", a2 - a1, 32'd81);
    send_cmd(8'h34, 32'h0, a1);
    send_cmd(8'h12, 32'h0, a2);
    repeat (110) @(negedge clk);
    loop_en = 1'b0;
    check("loop_rsp_drained", exp_rsp.size(), 32'd0);

    // Good byte, then a byte with a low stop bit, then flush
`ifndef SUMP_HOST_WORD_EN
    exp_rsp.push_back(32'h000000AA);
`endif
    rx_send(8'hAA, 1'b1);
    rx_send(8'h55, 1'b0);
    check("frame_err_count", fe_cnt, 32'd1);
`ifdef SUMP_HOST_WORD_EN
    exp_rsp.push_back(32'h000000AA);
`endif
    pulse_flush();
    repeat (4) @(negedge clk);
    check("flush_rsp_drained", exp_rsp.size(), 32'd0);

    // Three-clock glitch must produce nothing
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("glitch_no_frame_err", fe_cnt, 32'd1);
`ifndef SUMP_HOST_WORD_EN
    exp_rsp.push_back(32'h0000005A);
`endif
    rx_send(8'h5A, 1'b1);
`ifdef SUMP_HOST_WORD_EN
    exp_rsp.push_back(32'h0000005A);
`endif
    pulse_flush();
    repeat (4) @(negedge clk);
    pulse_flush();
    repeat (4) @(negedge clk);
    check("glitch_rsp_drained", exp_rsp.size(), 32'd0);

    // Reset during the third bit of a long command
    mon_en = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 8'hC0;
    bus.cmd_data  = 32'hCAFEF00D;
    lows = 0;
    while (bus.cmd_ready !== 1'b1 && lows < 2000) begin
      @(negedge clk);
      lows++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2 * BIT + 3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx_high", {31'h0, tx}, 32'h1);
    check("midrst_ready_low", {31'h0, bus.cmd_ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_release", {31'h0, bus.cmd_ready}, 32'h1);
    lows = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("midrst_tx_quiet", lows, 32'd0);
    mon_en = 1'b1;
    send_cmd(OP_XON, 32'h0, a0);
    repeat (90) @(negedge clk);

    check("txq_empty", exp_tx.size(), 32'd0);
    check("rspq_empty", exp_rsp.size(), 32'd0);
    check("frame_err_total", fe_cnt, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
